// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule generator.
//   - ks_state_t : key-expansion FSM state encoding
//   - NK/NR/NWORDS : AES-128 geometry constants
//   - RCON  : round-constant table (reference values)
//   - aes_sbox()  : forward AES S-box lookup
//   - aes_xtime() : GF(2^8) multiply-by-x used to advance Rcon
package aes_pkg;

  localparam int NK     = 4;
  localparam int NR     = 10;
  localparam int NWORDS = NK * (NR + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } ks_state_t;

  localparam logic [0:NR-1][7:0] RCON = 80'h01020408102040801b36;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    return SBOX[a];
  endfunction

  function automatic logic [7:0] aes_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four forward S-box lookups on a 32-bit word.
//   sub_in  : input word
//   sub_out : byte-wise S-box substitution of sub_in
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] sub_in,
  output logic [31:0] sub_out
);

  always_comb begin
    sub_out = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      sub_out[8*b +: 8] = aes_sbox(sub_in[8*b +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_schedule_gen.sv
// Iterative AES-128 key expansion, one schedule word per clock.
// Latches the cipher key in LOAD, produces w[4..43] in EXPAND and
// presents all eleven round keys on a registered 1408-bit bus.
//   CLK          : clock, rising edge
//   RESET_N      : synchronous active-low reset
//   KS_START     : level request, sampled in IDLE
//   AES_KEY      : cipher key (byte 0 in [127:120]), sampled in LOAD
//   KS_BUSY      : high in LOAD and EXPAND
//   KS_DONE      : high in DONE
//   KEY_SCHEDULE : round key r at [128r+127:128r], w[4r] in its top word
// Optional build macro KS_KEY_CACHE_EN: remembers the last expanded key
// and skips straight to DONE when the same key is requested again.
module aes_key_schedule_gen
  import aes_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   KS_START,
  input  logic [127:0]           AES_KEY,
  output logic                   KS_BUSY,
  output logic                   KS_DONE,
  output logic [NWORDS*32-1:0]   KEY_SCHEDULE
);

  ks_state_t    state_q, state_d;
  logic [5:0]   word_idx;
  logic [7:0]   rcon;
  // Sliding window of w[i-4..i-1]; w[i-4] in the top word, w[i-1] at the bottom.
  // Avoids variable-index reads of the wide schedule bus.
  logic [127:0] win;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  temp;
  logic [31:0]  new_word;
  logic [10:0]  wr_base;
  logic         cache_hit;
  logic         last_word;

  assign last_word = (word_idx == 6'(NWORDS - 1));

`ifdef KS_KEY_CACHE_EN
  logic [127:0] last_key;
  logic         cache_vld;

  assign cache_hit = cache_vld && (AES_KEY == last_key);

  // Round key 0 still holds the loaded key when expansion finishes.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cache_vld <= 1'b0;
      last_key  <= '0;
    end else if (state_q == EXPAND && state_d == DONE) begin
      cache_vld <= 1'b1;
      last_key  <= KEY_SCHEDULE[127:0];
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (KS_START) state_d = cache_hit ? DONE : LOAD;
      LOAD:    state_d = EXPAND;
      EXPAND:  if (last_word) state_d = DONE;
      DONE:    if (!KS_START) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign KS_BUSY = (state_q == LOAD) || (state_q == EXPAND);
  assign KS_DONE = (state_q == DONE);

  assign rot_word = {win[23:0], win[31:24]};

  aes_sub_word u_sub_word (
    .sub_in  (rot_word),
    .sub_out (sub_word)
  );

  assign temp     = (word_idx[1:0] == 2'd0) ? (sub_word ^ {rcon, 24'h0}) : win[31:0];
  assign new_word = win[127:96] ^ temp;

  // Bit offset of w[i]: 128*(i/4) + 32*(3 - i%4).
  assign wr_base  = {word_idx[5:2], 7'b0} + {4'b0, ~word_idx[1:0], 5'b0};

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      KEY_SCHEDULE <= '0;
      word_idx     <= '0;
      rcon         <= '0;
      win          <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          KEY_SCHEDULE[127:0] <= AES_KEY;
          win                 <= AES_KEY;
          word_idx            <= 6'd4;
          rcon                <= 8'h01;
        end
        EXPAND: begin
          KEY_SCHEDULE[wr_base +: 32] <= new_word;
          win                         <= {win[95:0], new_word};
          if (!last_word) word_idx <= word_idx + 6'd1;
          if (word_idx[1:0] == 2'd0) rcon <= aes_xtime(rcon);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_gen.sv
module tb_aes_key_schedule_gen;
  import aes_pkg::*;

  logic                 CLK = 1'b0;
  logic                 RESET_N;
  logic                 KS_START;
  logic [127:0]         AES_KEY;
  logic                 KS_BUSY;
  logic                 KS_DONE;
  logic [NWORDS*32-1:0] KEY_SCHEDULE;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ONES_RK1  = 128'he8e9e9e917161616e8e9e9e917161616;

`ifdef KS_KEY_CACHE_EN
  localparam int CACHED_LAT = 1;
`else
  localparam int CACHED_LAT = 42;
`endif

  aes_key_schedule_gen dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .KS_START     (KS_START),
    .AES_KEY      (AES_KEY),
    .KS_BUSY      (KS_BUSY),
    .KS_DONE      (KS_DONE),
    .KEY_SCHEDULE (KEY_SCHEDULE)
  );

  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return KEY_SCHEDULE[128*r +: 128];
  endfunction

  // Raise START with the given key and count edges (start edge included)
  // until KS_DONE is seen; bounded at 60 edges.
  task automatic run_req(input logic [127:0] key, input bit pulse, input bit scramble,
                         output int n);
    n = 0;
    @(negedge CLK);
    AES_KEY  = key;
    KS_START = 1'b1;
    do begin
      @(posedge CLK); #1;
      n++;
      if (pulse) KS_START = 1'b0;
      if (scramble && n >= 2) AES_KEY = {$urandom(), $urandom(), $urandom(), $urandom()};
    end while (!KS_DONE && n < 60);
  endtask

  task automatic release_start();
    @(negedge CLK);
    KS_START = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    RESET_N  = 1'b0;
    KS_START = 1'b0;
    AES_KEY  = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_value("reset_busy", 128'(KS_BUSY), 128'd0);
    check_value("reset_done", 128'(KS_DONE), 128'd0);
    check_value("reset_sched_zero", 128'(KEY_SCHEDULE == '0), 128'd1);
    @(negedge CLK);
    RESET_N = 1'b1;

    // FIPS-197 key, START held high
    run_req(KEY_FIPS, 1'b0, 1'b0, lat);
    check_value("fips_latency", 128'(lat), 128'd42);
    check_value("fips_w4", 128'(KEY_SCHEDULE[255:224]), 128'h a0fafe17);
    check_value("fips_w5", 128'(KEY_SCHEDULE[223:192]), 128'h 88542cb1);
    check_value("fips_rk0", rk(0), KEY_FIPS);
    check_value("fips_rk1", rk(1), FIPS_RK1);
    check_value("fips_rk2", rk(2), FIPS_RK2);
    check_value("fips_rk10", rk(10), FIPS_RK10);
    repeat (3) begin
      @(posedge CLK); #1;
    end
    check_value("done_hold", 128'(KS_DONE), 128'd1);
    check_value("done_hold_busy", 128'(KS_BUSY), 128'd0);
    release_start();
    check_value("done_exit", 128'(KS_DONE), 128'd0);

    // All-zero key, single-cycle START pulse
    run_req('0, 1'b1, 1'b0, lat);
    check_value("zero_latency", 128'(lat), 128'd42);
    check_value("zero_rk1", rk(1), ZERO_RK1);
    check_value("zero_rk2", rk(2), ZERO_RK2);
    check_value("zero_rk10", rk(10), ZERO_RK10);
    @(posedge CLK); #1;
    check_value("pulse_done_one_cycle", 128'(KS_DONE), 128'd0);
    check_value("pulse_idle_busy", 128'(KS_BUSY), 128'd0);

    // Same key again: cache hit when compiled in, full run otherwise
    run_req('0, 1'b0, 1'b0, lat);
    check_value("repeat_latency", 128'(lat), 128'(CACHED_LAT));
    check_value("repeat_rk10", rk(10), ZERO_RK10);
    release_start();

    // Different key, AES_KEY scrambled every cycle after LOAD
    run_req(KEY_FIPS, 1'b0, 1'b1, lat);
    check_value("scramble_latency", 128'(lat), 128'd42);
    check_value("scramble_rk0", rk(0), KEY_FIPS);
    check_value("scramble_rk10", rk(10), FIPS_RK10);
    release_start();

    // Reset partway through EXPAND
    @(negedge CLK);
    AES_KEY  = '1;
    KS_START = 1'b1;
    repeat (22) @(posedge CLK);
    #1;
    check_value("abort_busy_before", 128'(KS_BUSY), 128'd1);
    @(negedge CLK);
    RESET_N  = 1'b0;
    KS_START = 1'b0;
    @(posedge CLK); #1;
    check_value("abort_busy", 128'(KS_BUSY), 128'd0);
    check_value("abort_done", 128'(KS_DONE), 128'd0);
    check_value("abort_sched_zero", 128'(KEY_SCHEDULE == '0), 128'd1);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Restart with the last completed key: reset must have dropped any cache
    run_req(KEY_FIPS, 1'b0, 1'b0, lat);
    check_value("restart_latency", 128'(lat), 128'd42);
    check_value("restart_rk1", rk(1), FIPS_RK1);
    check_value("restart_rk10", rk(10), FIPS_RK10);
    release_start();

    // All-ones key
    run_req('1, 1'b1, 1'b0, lat);
    check_value("ones_latency", 128'(lat), 128'd42);
    check_value("ones_rk0", rk(0), '1);
    check_value("ones_rk1", rk(1), ONES_RK1);
    @(posedge CLK); #1;
    check_value("ones_idle", 128'(KS_DONE), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_gen.md
# aes_key_schedule_gen

Iterative AES-128 key expansion engine for the decryption datapath. It sits directly upstream of the AES decryption core. It latches the 128-bit cipher key and computes the 44-word key schedule, one word per clock. It presents all eleven round keys as one registered 1408-bit bus, which the core's AddRoundKey stage indexes by round number. A start/done handshake lets the core's key-expansion wait state key off KS_DONE instead of a fixed cycle count.

## Interface
- No parameters. AES-128 only; the word count (44) and round-key count (11) are package constants.
- CLK  in  1  sole clock; all state updates on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- KS_START  in  1  level request. Sampled in IDLE.
- AES_KEY  in  128  cipher key; byte 0 in bits [127:120]. Sampled only in LOAD.
- KS_BUSY  out  1  high in LOAD and EXPAND. Reset 0.
- KS_DONE  out  1  high in DONE only. Reset 0.
- KEY_SCHEDULE  out  1408  round key r is at bits [128r+127:128r]; word w[4r] is in the top 32 bits of that slice. Reset all-zero.

## Operation
- FSM states: IDLE, LOAD, EXPAND, DONE. Reset state is IDLE.
- IDLE -> LOAD when KS_START=1.
- LOAD:
  - w[0..3] <= AES_KEY.
  - Word index i <= 4.
  - Rcon register <= 8'h01.
  - Always goes to EXPAND.
- EXPAND computes one word per cycle:
  - temp = w[i-1].
  - If i mod 4 = 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}. Rcon then advances by xtime: 01,02,04,08,10,20,40,80,1b,36.
  - w[i] <= w[i-4] ^ temp; i <= i+1.
  - After w[43] is written, the FSM goes to DONE.
- The index counter is 6 bits and spans 4..43. It never wraps, because the FSM leaves EXPAND when i=43.
- DONE -> IDLE when KS_START=0. DONE holds while KS_START stays high.
- If KS_START drops during LOAD or EXPAND, expansion still completes. DONE is then shown for exactly one cycle before returning to IDLE.
- AES_KEY changes after LOAD are ignored until the next request.
- KEY_SCHEDULE is written in place and is only guaranteed consistent while KS_DONE=1. Words not yet rewritten keep their previous values.
- Reset mid-operation (RESET_N=0 on any edge):
  - State goes to IDLE and all outputs take their reset values.
  - The index and Rcon registers clear.
  - With the cache compiled in, the cache-valid bit clears.

## Timing
- KS_START is sampled high in IDLE at edge k.
- LOAD is registered at k+1 (KS_BUSY=1).
- EXPAND runs for 40 cycles, k+2..k+41.
- DONE is registered at k+42 (KS_DONE=1), so latency is 42 cycles from the start edge.
- KEY_SCHEDULE is registered with no combinational path from inputs. The SubWord path is one cycle deep: S-box lookup, then two XORs.
- Back-to-back requests: with START toggled low for one cycle, the next LOAD is no earlier than 2 cycles after DONE exits.

## Configuration
- Macro KS_KEY_CACHE_EN.
- Defined:
  - A 128-bit last-key register and a cache-valid bit are added.
  - Both are set on the EXPAND->DONE transition.
  - In IDLE, if KS_START=1, cache-valid=1 and AES_KEY equals last-key, the FSM goes directly to DONE at k+1 (latency 1). KEY_SCHEDULE is unchanged.
  - A mismatch takes the normal path.
- Undefined: every request runs the full 42-cycle expansion, and no cache registers exist.

## Structure
- Shared package aes_pkg holds:
  - the FSM state enum;
  - the constants NK=4, NR=10, NWORDS=44;
  - the Rcon table, as a reference for the bench;
  - the forward S-box function.
- One sub-module, aes_sub_word: a combinational 32-bit SubWord built from four forward S-box lookups. This is the forward S-box, not the inverse S-box used by the decryption datapath.
- RotWord, the Rcon xtime update and the word XOR stay inline.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, START high ->
  - KS_DONE rises exactly 42 cycles after the start edge;
  - w[4]=a0fafe17 and w[5]=88542cb1;
  - KEY_SCHEDULE[1407:1280]=d014f9a8c9ee2589e13f0cc8b6630ca6;
  - KEY_SCHEDULE[127:0] equals the key.
- All-zero key -> round key 1 = 62636363626363636263636362636363 and round key 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- RESET_N low at cycle 20 of EXPAND -> next cycle KS_BUSY=0, KS_DONE=0, KEY_SCHEDULE=0. A restart then yields the correct schedule.
- START pulsed for a single cycle -> full expansion runs, KS_DONE high for exactly one cycle, FSM returns to IDLE.
- AES_KEY changed every cycle during EXPAND -> result matches the key present at LOAD.
- With KS_KEY_CACHE_EN, the same key is requested twice -> the second KS_DONE comes one cycle after START with KEY_SCHEDULE unchanged. A different key takes 42 cycles.
